// File: rtl/reg_file_scoreboard_if.sv
// rtl/reg_file_scoreboard_if.sv - decode/writeback bundle for the register file and pending-write scoreboard
//
// Purpose: groups every non-clock, non-reset signal of reg_file_scoreboard.
// Port summary:
//   pipeline control : stall, flush
//   writeback port   : wbRegWrite, wbRd[4:0], wbData[31:0]
//   decode reads     : rs1Addr/rs2Addr[4:0], rs1Used/rs2Used, rs1Data/rs2Data[31:0]
//   decode issue     : issueValid, issueRd[4:0], issueWrites, hazard
// master = pipeline side (drives requests), slave = register file side.

interface reg_file_scoreboard_if;
    logic        stall;
    logic        flush;
    logic        wbRegWrite;
    logic [4:0]  wbRd;
    logic [31:0] wbData;
    logic [4:0]  rs1Addr;
    logic [4:0]  rs2Addr;
    logic        rs1Used;
    logic        rs2Used;
    logic        issueValid;
    logic [4:0]  issueRd;
    logic        issueWrites;
    logic [31:0] rs1Data;
    logic [31:0] rs2Data;
    logic        hazard;

    modport master (
        output stall, flush,
        output wbRegWrite, wbRd, wbData,
        output rs1Addr, rs2Addr, rs1Used, rs2Used,
        output issueValid, issueRd, issueWrites,
        input  rs1Data, rs2Data, hazard
    );

    modport slave (
        input  stall, flush,
        input  wbRegWrite, wbRd, wbData,
        input  rs1Addr, rs2Addr, rs1Used, rs2Used,
        input  issueValid, issueRd, issueWrites,
        output rs1Data, rs2Data, hazard
    );
endinterface

// File: rtl/reg_file_scoreboard.sv
// rtl/reg_file_scoreboard.sv - RV32I architectural register file with pending-write scoreboard
//
// Purpose: stores x1..x31, bypasses a same-cycle writeback to both read
// ports, and keeps a 2-bit count of issued-but-unretired writes per register
// so decode can be held on a read-after-write or counter-saturation hazard.
// Ports:
//   clk     in   clock, all state updates on posedge
//   reset   in   synchronous, active-high
//   bus     slave modport of reg_file_scoreboard_if (see that file)

module reg_file_scoreboard (
    input  logic                 clk,
    input  logic                 reset,
    reg_file_scoreboard_if.slave bus
);

    logic [31:0] regs_q [1:31];
    logic [31:0] regs_d [1:31];
    logic [1:0]  pend_q [1:31];
    logic [1:0]  pend_d [1:31];

    logic        commit;
    logic        issue;
    logic        flush_eff;
    logic [31:0] rs1_reg;
    logic [31:0] rs2_reg;
    logic [1:0]  rs1_pend;
    logic [1:0]  rs2_pend;
    logic [1:0]  rd_pend;
    logic        rs1_ret;
    logic        rs2_ret;
    logic        rd_ret;
    logic        src1_haz;
    logic        src2_haz;
    logic        sat_haz;
    logic        hazard_w;

    // A held writeback latch retires only on the first unstalled edge.
    assign commit    = bus.wbRegWrite & ~bus.stall & (bus.wbRd != 5'd0);
    assign flush_eff = bus.flush & ~bus.stall;

    // Array lookups by address; index 0 has no storage and reads as 0.
    always_comb begin
        rs1_reg  = '0;
        rs2_reg  = '0;
        rs1_pend = '0;
        rs2_pend = '0;
        rd_pend  = '0;
        for (int r = 1; r < 32; r++) begin
            if (bus.rs1Addr == 5'(r)) begin
                rs1_reg  = regs_q[r];
                rs1_pend = pend_q[r];
            end
            if (bus.rs2Addr == 5'(r)) begin
                rs2_reg  = regs_q[r];
                rs2_pend = pend_q[r];
            end
            if (bus.issueRd == 5'(r)) begin
                rd_pend = pend_q[r];
            end
        end
    end

    assign rs1_ret = commit & (bus.wbRd == bus.rs1Addr);
    assign rs2_ret = commit & (bus.wbRd == bus.rs2Addr);
    assign rd_ret  = commit & (bus.wbRd == bus.issueRd);

    assign bus.rs1Data = (bus.rs1Addr == 5'd0) ? 32'd0 :
                         rs1_ret               ? bus.wbData : rs1_reg;
    assign bus.rs2Data = (bus.rs2Addr == 5'd0) ? 32'd0 :
                         rs2_ret               ? bus.wbData : rs2_reg;

    // A source is clear once only the retiring write remains (it is bypassed).
    // A commit against an already-zero count (after a flush) does not wrap
    // into a hazard.
    assign src1_haz = bus.rs1Used & (bus.rs1Addr != 5'd0) & (rs1_pend != 2'd0) &
                      ~((rs1_pend == 2'd1) & rs1_ret);
    assign src2_haz = bus.rs2Used & (bus.rs2Addr != 5'd0) & (rs2_pend != 2'd0) &
                      ~((rs2_pend == 2'd1) & rs2_ret);

    // A fourth outstanding write would overflow the counter unless one retires now.
    assign sat_haz  = bus.issueValid & bus.issueWrites & (bus.issueRd != 5'd0) &
                      (rd_pend == 2'd3) & ~rd_ret;

    assign hazard_w   = bus.issueValid & (src1_haz | src2_haz | sat_haz);
    assign bus.hazard = hazard_w;

    assign issue = bus.issueValid & bus.issueWrites & ~hazard_w & ~bus.stall &
                   (bus.issueRd != 5'd0);

    always_comb begin
        for (int r = 1; r < 32; r++) begin
            regs_d[r] = regs_q[r];
            pend_d[r] = pend_q[r];
        end
        for (int r = 1; r < 32; r++) begin
            if (commit && (bus.wbRd == 5'(r))) begin
                regs_d[r] = bus.wbData;
            end
            if (flush_eff) begin
                // Squashed instructions never retire; issue this cycle is dropped too.
                pend_d[r] = 2'd0;
            end else if (issue && (bus.issueRd == 5'(r)) &&
                         commit && (bus.wbRd == 5'(r))) begin
                pend_d[r] = pend_q[r];
            end else if (issue && (bus.issueRd == 5'(r))) begin
                pend_d[r] = pend_q[r] + 2'd1;
            end else if (commit && (bus.wbRd == 5'(r)) && (pend_q[r] != 2'd0)) begin
                pend_d[r] = pend_q[r] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 1; r < 32; r++) begin
                regs_q[r] <= '0;
                pend_q[r] <= '0;
            end
        end else begin
            for (int r = 1; r < 32; r++) begin
                regs_q[r] <= regs_d[r];
                pend_q[r] <= pend_d[r];
            end
        end
    end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// tb/tb_reg_file_scoreboard.sv - directed self-checking bench for reg_file_scoreboard

module tb_reg_file_scoreboard;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    reg_file_scoreboard_if rf_if ();

    reg_file_scoreboard dut (
        .clk   (clk),
        .reset (reset),
        .bus   (rf_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rf_if.stall       = 1'b0;
        rf_if.flush       = 1'b0;
        rf_if.wbRegWrite  = 1'b0;
        rf_if.wbRd        = 5'd0;
        rf_if.wbData      = 32'd0;
        rf_if.rs1Addr     = 5'd0;
        rf_if.rs2Addr     = 5'd0;
        rf_if.rs1Used     = 1'b0;
        rf_if.rs2Used     = 1'b0;
        rf_if.issueValid  = 1'b0;
        rf_if.issueRd     = 5'd0;
        rf_if.issueWrites = 1'b0;
    endtask

    task automatic issue_once(input logic [4:0] rd);
        idle();
        rf_if.issueValid  = 1'b1;
        rf_if.issueWrites = 1'b1;
        rf_if.issueRd     = rd;
        #1;
        check_val($sformatf("issue_x%0d_nohaz", rd), 32'(rf_if.hazard), 32'd0);
        tick();
    endtask

    // Read a register through rs1 with an issuing non-writing instruction.
    task automatic probe(input string tag, input logic [4:0] rs,
                         input logic [31:0] exp_data, input logic exp_haz);
        idle();
        rf_if.rs1Addr    = rs;
        rf_if.rs1Used    = 1'b1;
        rf_if.issueValid = 1'b1;
        #1;
        check_val({tag, "_data"}, rf_if.rs1Data, exp_data);
        check_val({tag, "_haz"}, 32'(rf_if.hazard), 32'(exp_haz));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check_val("reset_rs1", rf_if.rs1Data, 32'd0);
        check_val("reset_rs2", rf_if.rs2Data, 32'd0);
        check_val("reset_haz", 32'(rf_if.hazard), 32'd0);

        // 1: bypass then registered read of x5, x0 reads 0
        rf_if.wbRegWrite = 1'b1;
        rf_if.wbRd       = 5'd5;
        rf_if.wbData     = 32'hDEADBEEF;
        rf_if.rs1Addr    = 5'd5;
        #1;
        check_val("t1_bypass", rf_if.rs1Data, 32'hDEADBEEF);
        check_val("t1_x0_port2", rf_if.rs2Data, 32'd0);
        tick();
        probe("t1_x5_reg", 5'd5, 32'hDEADBEEF, 1'b0);
        probe("t1_x0", 5'd0, 32'd0, 1'b0);

        // 2: commit to x0 is ignored
        idle();
        rf_if.wbRegWrite = 1'b1;
        rf_if.wbRd       = 5'd0;
        rf_if.wbData     = 32'h1234;
        #1;
        check_val("t2_x0_same", rf_if.rs1Data, 32'd0);
        tick();
        probe("t2_x0_after", 5'd0, 32'd0, 1'b0);

        // 3: RAW hazard on x7 cleared by same-cycle retire
        tick();
        issue_once(5'd7);
        probe("t3_pend", 5'd7, 32'd0, 1'b1);
        rf_if.wbRegWrite = 1'b1;
        rf_if.wbRd       = 5'd7;
        rf_if.wbData     = 32'h55;
        #1;
        check_val("t3_ret_data", rf_if.rs1Data, 32'h55);
        check_val("t3_ret_haz", 32'(rf_if.hazard), 32'd0);
        tick();
        probe("t3_after", 5'd7, 32'h55, 1'b0);

        // 4: held writeback retires exactly once
        tick();
        issue_once(5'd3);
        issue_once(5'd3);
        idle();
        rf_if.stall      = 1'b1;
        rf_if.wbRegWrite = 1'b1;
        rf_if.wbRd       = 5'd3;
        rf_if.wbData     = 32'hA5A5A5A5;
        rf_if.rs1Addr    = 5'd3;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val($sformatf("t4_stall%0d_nobypass", i), rf_if.rs1Data, 32'd0);
            tick();
        end
        rf_if.stall = 1'b0;
        tick();
        probe("t4_one_left", 5'd3, 32'hA5A5A5A5, 1'b1);
        rf_if.wbRegWrite = 1'b1;
        rf_if.wbRd       = 5'd3;
        rf_if.wbData     = 32'h0BADF00D;
        #1;
        check_val("t4_last_ret_haz", 32'(rf_if.hazard), 32'd0);
        tick();
        probe("t4_cleared", 5'd3, 32'h0BADF00D, 1'b0);

        // 5: saturation of x9 and simultaneous issue+commit
        tick();
        issue_once(5'd9);
        issue_once(5'd9);
        issue_once(5'd9);
        idle();
        rf_if.issueValid  = 1'b1;
        rf_if.issueWrites = 1'b1;
        rf_if.issueRd     = 5'd9;
        #1;
        check_val("t5_sat_haz", 32'(rf_if.hazard), 32'd1);
        rf_if.wbRegWrite = 1'b1;
        rf_if.wbRd       = 5'd9;
        rf_if.wbData     = 32'h99;
        #1;
        check_val("t5_sat_ret", 32'(rf_if.hazard), 32'd0);
        tick();
        idle();
        rf_if.issueValid  = 1'b1;
        rf_if.issueWrites = 1'b1;
        rf_if.issueRd     = 5'd9;
        #1;
        check_val("t5_still3", 32'(rf_if.hazard), 32'd1);
        rf_if.issueWrites = 1'b0;
        rf_if.rs2Addr     = 5'd9;
        rf_if.rs2Used     = 1'b1;
        #1;
        check_val("t5_rs2_haz", 32'(rf_if.hazard), 32'd1);
        check_val("t5_rs2_data", rf_if.rs2Data, 32'h99);

        // 6: flush clears counters, later commit keeps pend at 0
        tick();
        issue_once(5'd4);
        issue_once(5'd4);
        probe("t6_pend2", 5'd4, 32'd0, 1'b1);
        idle();
        rf_if.flush = 1'b1;
        tick();
        probe("t6_flushed", 5'd4, 32'd0, 1'b0);
        probe("t6_x9_flushed", 5'd9, 32'h99, 1'b0);
        idle();
        rf_if.wbRegWrite = 1'b1;
        rf_if.wbRd       = 5'd4;
        rf_if.wbData     = 32'h77;
        tick();
        probe("t6_late_commit", 5'd4, 32'h77, 1'b0);

        // Reset mid-operation drops the writeback and clears everything
        tick();
        issue_once(5'd12);
        idle();
        reset            = 1'b1;
        rf_if.wbRegWrite = 1'b1;
        rf_if.wbRd       = 5'd12;
        rf_if.wbData     = 32'hFFFF0000;
        tick();
        reset = 1'b0;
        probe("rst_x12", 5'd12, 32'd0, 1'b0);
        probe("rst_x5", 5'd5, 32'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
